// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end: BTB entry layout and
// PC-to-index/tag extraction.
package fetch_pkg;

  localparam int INSN_BYTES = 4;

  // The tag field is sized for the smallest legal index width. Shorter tags
  // are zero-extended, so comparisons stay exact for any depth.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return 30'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with a combinational read port and a
// synchronous write port. A read and a write in the same cycle return the old entry.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t     mem [ENTRIES];
  btb_entry_t     rd_entry;
  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;

  assign rd_idx    = IDX'(btb_idx(rd_pc, IDX));
  assign wr_idx    = IDX'(btb_idx(wr_pc, IDX));
  assign rd_entry  = mem[rd_idx];
  assign rd_hit    = rd_entry.valid && (rd_entry.tag == btb_tag(rd_pc, IDX));
  assign rd_target = rd_entry.target;

  // Only the valid bits are cleared; stale tags and targets are never observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= '{valid: 1'b1, tag: btb_tag(wr_pc, IDX), target: wr_target};
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Two-stage next-PC generator: F0 issues the fetch address, F1 presents the
// packet to decode and turns a predicted-taken BTB hit into a redirect.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_pc,
  output logic        fetch_en,
  input  logic        predict_take,
  output logic        if_vld,
  input  logic        if_rdy,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_btb_wr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target
);

  // Handshake: decode takes the F1 packet on a cycle with if_vld && if_rdy.
  // if_vld drops in the same cycle as ex_redirect, so a flushed packet is never taken.
  logic [31:0] pc_f0;
  logic        f1_vld;
  logic [31:0] f1_pc;
  logic        f1_hit;
  logic [31:0] f1_tgt;
  logic        f1_pred_q;
  logic        f1_fresh;

  logic        btb_hit;
  logic [31:0] btb_tgt;
  logic        pred;
  logic        stall;
  logic        take;

  fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (pc_f0),
    .rd_hit    (btb_hit),
    .rd_target (btb_tgt),
    .wr_en     (ex_btb_wr),
    .wr_pc     (ex_pc),
    .wr_target (ex_target)
  );

  // The predictor tracks F0, so its answer for F1 is valid only on the first
  // F1 cycle. After that cycle the captured copy holds through stalls.
  assign pred  = f1_fresh ? predict_take : f1_pred_q;
  assign stall = f1_vld && !if_rdy;
  assign take  = f1_vld && if_rdy && pred && f1_hit;

  assign fetch_pc       = pc_f0;
  assign fetch_en       = !rst && (ex_redirect || !stall);
  assign if_vld         = !rst && f1_vld && !ex_redirect;
  assign if_pc          = f1_pc;
  assign if_pred_taken  = !rst && f1_vld && pred && f1_hit;
  assign if_pred_target = f1_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f0     <= RESET_PC;
      f1_vld    <= 1'b0;
      f1_pc     <= '0;
      f1_hit    <= 1'b0;
      f1_tgt    <= '0;
      f1_pred_q <= 1'b0;
      f1_fresh  <= 1'b0;
    end else begin
      if (f1_fresh) begin
        f1_pred_q <= predict_take;
        f1_fresh  <= 1'b0;
      end
      if (ex_redirect) begin
        pc_f0  <= ex_redirect_pc;
        f1_vld <= 1'b0;
      end else if (stall) begin
        pc_f0  <= pc_f0;
        f1_vld <= f1_vld;
      end else if (take) begin
        pc_f0  <= f1_tgt;
        f1_vld <= 1'b0;
      end else begin
        pc_f0    <= pc_f0 + 32'(INSN_BYTES);
        f1_vld   <= 1'b1;
        f1_pc    <= pc_f0;
        f1_hit   <= btb_hit;
        f1_tgt   <= btb_tgt;
        f1_fresh <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: scoreboard of accepted decode packets plus
// cycle-level checks of fetch_pc, fetch_en and the F1 outputs.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        predict_take;
  logic        if_vld;
  logic        if_rdy;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        ex_btb_wr;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;

  logic        pt_en;
  logic        pt_kill;
  logic [31:0] pt_pc;

  int n_chk;
  int n_fail;

  // Packet = {pred_taken, pc, target}
  logic [64:0] exp_q[$];

  fetch_pc_gen #(.RESET_PC(32'h0000_0100), .BTB_ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .fetch_en       (fetch_en),
    .predict_take   (predict_take),
    .if_vld         (if_vld),
    .if_rdy         (if_rdy),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
    .ex_btb_wr      (ex_btb_wr),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
    exp_q.push_back({taken, pc, tgt});
  endtask

  // Advance one cycle; the stand-in predictor answers for the previous fetch_pc.
  task automatic step();
    logic [31:0] prev;
    prev = fetch_pc;
    @(posedge clk);
    #1;
    predict_take = pt_en && (prev == pt_pc) && !pt_kill;
    #1;
  endtask

  // Returns in cycle 0 after rst falls.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst          = 1'b1;
    if_rdy       = 1'b1;
    ex_redirect  = 1'b0;
    ex_btb_wr    = 1'b0;
    pt_kill      = 1'b0;
    predict_take = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_if_vld", 32'(if_vld), 32'd0);
    chk("rst_if_pred_taken", 32'(if_pred_taken), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic btb_write(input logic [31:0] pc, input logic [31:0] tgt);
    ex_btb_wr = 1'b1;
    ex_pc     = pc;
    ex_target = tgt;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && if_vld && if_rdy) begin
      logic [64:0] e;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected: actual pc %h required no packet", if_pc);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e[63:32] || if_pred_taken !== e[64] ||
            (e[64] && if_pred_target !== e[31:0])) begin
          n_fail++;
          $display("FAIL pkt: actual pc %h taken %b tgt %h required pc %h taken %b tgt %h",
                   if_pc, if_pred_taken, if_pred_target, e[63:32], e[64], e[31:0]);
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; if_rdy = 1'b1; predict_take = 1'b0;
    ex_redirect = 1'b0; ex_redirect_pc = '0;
    ex_btb_wr = 1'b0; ex_pc = '0; ex_target = '0;
    pt_en = 1'b0; pt_kill = 1'b0; pt_pc = '0;

    // Sequential fetch; predict_take on 0x104 with an empty BTB.
    pt_en = 1'b1; pt_pc = 32'h104;
    do_reset();
    chk("a_c0_fetch_pc", fetch_pc, 32'h100);
    chk("a_c0_fetch_en", 32'(fetch_en), 32'd1);
    chk("a_c0_if_vld", 32'(if_vld), 32'd0);
    push(0, 32'h100, 0); push(0, 32'h104, 0); push(0, 32'h108, 0); push(0, 32'h10C, 0);
    step();
    chk("a_c1_if_vld", 32'(if_vld), 32'd1);
    chk("a_c1_if_pc", if_pc, 32'h100);
    chk("a_c1_fetch_pc", fetch_pc, 32'h104);
    step();
    chk("a_c2_fetch_pc", fetch_pc, 32'h108);
    chk("a_c2_predict_take_miss", 32'(if_pred_taken), 32'd0);
    step();
    chk("a_c3_fetch_pc", fetch_pc, 32'h10C);
    step();
    chk("a_c4_if_pc", if_pc, 32'h10C);

    // BTB hit on 0x108 -> 0x200 with one bubble.
    pt_pc = 32'h108;
    do_reset();
    btb_write(32'h108, 32'h200);
    push(0, 32'h100, 0); push(0, 32'h104, 0); push(1, 32'h108, 32'h200); push(0, 32'h200, 0);
    step();
    ex_btb_wr = 1'b0;
    step();
    step();
    chk("b_c3_if_pc", if_pc, 32'h108);
    chk("b_c3_pred_taken", 32'(if_pred_taken), 32'd1);
    chk("b_c3_pred_target", if_pred_target, 32'h200);
    step();
    chk("b_c4_fetch_pc", fetch_pc, 32'h200);
    chk("b_c4_bubble", 32'(if_vld), 32'd0);
    step();
    chk("b_c5_if_pc", if_pc, 32'h200);

    // Stall three cycles with the branch in F1; the prediction must survive.
    do_reset();
    btb_write(32'h108, 32'h200);
    push(0, 32'h100, 0); push(0, 32'h104, 0); push(1, 32'h108, 32'h200); push(0, 32'h200, 0);
    step();
    ex_btb_wr = 1'b0;
    step();
    step();
    if_rdy = 1'b0;
    #1;
    chk("c_c3_fetch_en", 32'(fetch_en), 32'd0);
    chk("c_c3_if_pc", if_pc, 32'h108);
    pt_kill = 1'b1;
    step();
    chk("c_c4_fetch_pc_hold", fetch_pc, 32'h10C);
    chk("c_c4_fetch_en", 32'(fetch_en), 32'd0);
    step();
    chk("c_c5_pred_held", 32'(if_pred_taken), 32'd1);
    step();
    if_rdy = 1'b1;
    #1;
    chk("c_c6_pred_target", if_pred_target, 32'h200);
    step();
    chk("c_c7_fetch_pc", fetch_pc, 32'h200);
    chk("c_c7_bubble", 32'(if_vld), 32'd0);
    step();
    chk("c_c8_if_pc", if_pc, 32'h200);

    // ex_redirect to 0x400 during a stall; the stalled 0x100 is never taken.
    pt_en = 1'b0;
    do_reset();
    push(0, 32'h400, 0); push(0, 32'h404, 0);
    step();
    if_rdy = 1'b0;
    step();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h400;
    #1;
    chk("d_c2_if_vld_flush", 32'(if_vld), 32'd0);
    step();
    ex_redirect = 1'b0; if_rdy = 1'b1;
    #1;
    chk("d_c3_fetch_pc", fetch_pc, 32'h400);
    chk("d_c3_if_vld", 32'(if_vld), 32'd0);
    step();
    chk("d_c4_if_vld", 32'(if_vld), 32'd1);
    chk("d_c4_if_pc", if_pc, 32'h400);
    step();
    chk("d_c5_if_pc", if_pc, 32'h404);

    // Aliasing 0x108/0x148, then a same-cycle write/lookup of index 2.
    pt_en = 1'b1; pt_pc = 32'h108;
    do_reset();
    push(0, 32'h100, 0); push(0, 32'h104, 0); push(0, 32'h108, 0);
    push(1, 32'h108, 32'h500); push(0, 32'h500, 0);
    btb_write(32'h108, 32'h200);
    step();
    btb_write(32'h148, 32'h300);
    step();
    chk("e_c2_fetch_pc", fetch_pc, 32'h108);
    btb_write(32'h108, 32'h500);
    step();
    ex_btb_wr = 1'b0;
    chk("e_c3_if_pc", if_pc, 32'h108);
    chk("e_c3_alias_miss", 32'(if_pred_taken), 32'd0);
    step();
    chk("e_c4_fetch_pc_seq", fetch_pc, 32'h110);
    ex_redirect = 1'b1; ex_redirect_pc = 32'h108;
    #1;
    chk("e_c4_if_vld_flush", 32'(if_vld), 32'd0);
    step();
    ex_redirect = 1'b0;
    chk("e_c5_fetch_pc", fetch_pc, 32'h108);
    step();
    chk("e_c6_pred_taken", 32'(if_pred_taken), 32'd1);
    chk("e_c6_pred_target", if_pred_target, 32'h500);
    step();
    chk("e_c7_fetch_pc", fetch_pc, 32'h500);
    step();
    chk("e_c8_if_pc", if_pc, 32'h500);

    // Mid-run reset must invalidate the BTB entry for 0x108.
    do_reset();
    push(0, 32'h100, 0); push(0, 32'h104, 0); push(0, 32'h108, 0); push(0, 32'h10C, 0);
    step();
    step();
    step();
    chk("f_c3_if_pc", if_pc, 32'h108);
    chk("f_c3_btb_cleared", 32'(if_pred_taken), 32'd0);
    step();
    chk("f_c4_fetch_pc", fetch_pc, 32'h110);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
